// File: rtl/comparator_capture_multi_if.sv
// comparator_capture_multi_if: sweep control, comparator inputs and capture results of the multi-channel capture block
interface comparator_capture_multi_if #(
    parameter int WIDTH = 8,
    parameter int NUM_CH = 4
);
    logic sweep_start;
    logic edge_sel;
    logic [NUM_CH-1:0] comparator_output;
    logic [WIDTH-1:0] current_duty_cycle;
    logic [NUM_CH*WIDTH-1:0] captured_duty_cycle;
    logic [NUM_CH-1:0] capture_valid;
    logic [NUM_CH-1:0] no_crossing;
    modport master (
        output sweep_start, edge_sel, comparator_output, current_duty_cycle,
        input captured_duty_cycle, capture_valid, no_crossing
    );
    modport slave (
        input sweep_start, edge_sel, comparator_output, current_duty_cycle,
        output captured_duty_cycle, capture_valid, no_crossing
    );
endinterface

// File: rtl/comparator_capture_multi.sv
// comparator_capture_multi: per-channel synchronised, debounced comparator-crossing capture of a shared ramp code
module comparator_capture_multi #(
    parameter int WIDTH = 8,
    parameter int NUM_CH = 4,
    parameter int STABLE_CYCLES = 15
) (
    input logic clk,
    input logic reset,
    comparator_capture_multi_if.slave bus
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [1:0] ARMED = 2'd0, FILTER = 2'd1, DONE = 2'd2;
    logic pre;
    logic seen_q, seen_d;
    logic [NUM_CH-1:0] sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [NUM_CH-1:0] valid_q, valid_d, nc_q, nc_d;
    logic [NUM_CH-1:0][1:0] state_q, state_d;
    logic [NUM_CH-1:0][CW-1:0] cnt_q, cnt_d;
    logic [NUM_CH-1:0][WIDTH-1:0] temp_q, temp_d, cap_q, cap_d;
    assign pre = ~bus.edge_sel;
    assign bus.captured_duty_cycle = cap_q;
    assign bus.capture_valid = valid_q;
    assign bus.no_crossing = nc_q;
    always_comb begin
        sync1_d = bus.comparator_output;
        sync2_d = sync1_q;
        prev_d = sync2_q;
        state_d = state_q;
        cnt_d = cnt_q;
        temp_d = temp_q;
        cap_d = cap_q;
        valid_d = '0;
        nc_d = nc_q;
        seen_d = seen_q | bus.sweep_start;
        for (int i = 0; i < NUM_CH; i++) begin
            if (state_q[i] == FILTER) begin
                if (sync2_q[i] == pre) state_d[i] = ARMED;
                else if (cnt_q[i] == CW'(1)) begin
                    cap_d[i] = temp_q[i];
                    valid_d[i] = 1'b1;
                    nc_d[i] = 1'b0;
                    state_d[i] = DONE;
                end else cnt_d[i] = cnt_q[i] - CW'(1);
            end else if (state_q[i] == ARMED && prev_q[i] == pre && sync2_q[i] != pre) begin
                temp_d[i] = bus.current_duty_cycle;
                cnt_d[i] = CW'(STABLE_CYCLES);
                state_d[i] = FILTER;
            end
            // a capture completing on the sweep edge still counts as this sweep's crossing
            if (bus.sweep_start) begin
                state_d[i] = ARMED;
                if (seen_q && state_q[i] != DONE && !valid_d[i]) nc_d[i] = 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q <= {NUM_CH{pre}};
            sync2_q <= {NUM_CH{pre}};
            prev_q <= {NUM_CH{pre}};
            state_q <= {NUM_CH{ARMED}};
            cnt_q <= '0;
            temp_q <= '0;
            cap_q <= '0;
            valid_q <= '0;
            nc_q <= '0;
            seen_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q <= prev_d;
            state_q <= state_d;
            cnt_q <= cnt_d;
            temp_q <= temp_d;
            cap_q <= cap_d;
            valid_q <= valid_d;
            nc_q <= nc_d;
            seen_q <= seen_d;
        end
    end
endmodule
